// File: rtl/mem_pkg.sv
// Shared types and defaults for the wait-stated memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int unsigned DEF_DEPTH_WORDS = 1024;
  localparam int unsigned DEF_WAIT_CYCLES = 2;

  // Misaligned or beyond the backing array.
  function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between an initiator and mem_responder.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with per-byte write enables; contents are never reset.
module mem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    be_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Byte-masked write or registered read of one word.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: captures a request, waits WAIT_CYCLES,
// performs one RAM access and holds the response until the initiator takes it.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES - 1);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic          err_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic          resp_err_q;
  logic          load_ok_q;
  logic          ram_en;
  logic [31:0]   ram_rdata;

  // Request capture, wait-state countdown and response sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'h0;
      be_q       <= 4'h0;
      resp_err_q <= 1'b0;
      load_ok_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            err_q   <= addr_err(bus.req_addr, 32'(DEPTH_WORDS));
            idx_q   <= bus.req_addr[AW+1:2];
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
            if (WAIT_CYCLES > 0) begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_INIT;
            end else begin
              state_q <= ST_ACCESS;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_ACCESS;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_ACCESS: begin
          state_q    <= ST_RESP;
          resp_err_q <= err_q;
          load_ok_q  <= !we_q && !err_q;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // The RAM is touched only in ACCESS; a reset on that edge suppresses the write.
  assign ram_en = (state_q == ST_ACCESS) && !err_q && !rst;

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk    (clk),
    .en_i   (ram_en),
    .we_i   (we_q),
    .addr_i (idx_q),
    .wdata_i(wdata_q),
    .be_i   (be_q),
    .rdata_o(ram_rdata)
  );

  assign bus.req_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.resp_valid = (state_q == ST_RESP) && !rst;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = load_ok_q ? ram_rdata : 32'h0;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, is the number of 32-bit words in the backing array and SHALL be a power of two.
REQ-002 Parameter WAIT_CYCLES, default 2, is the number of wait-state cycles inserted before each access; the legal range is 0..15.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  1  the initiator presents a request.
REQ-006 req_ready  output  1  the responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  store byte enables; bit i covers wdata[8i+7:8i].
REQ-011 resp_valid  output  1  a response is present.
REQ-012 resp_ready  input  1  the initiator accepts the response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  the request was misaligned or out of range.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, ACCESS and RESP; req_ready = (state == IDLE), and resp_valid = (state == RESP).
REQ-016 A request SHALL be accepted in any cycle N where req_valid && req_ready; we, addr, wdata and be are captured at the end of cycle N.
REQ-017 Transitions: IDLE→WAIT on accept if WAIT_CYCLES>0, otherwise IDLE→ACCESS; WAIT→ACCESS after exactly WAIT_CYCLES cycles in WAIT, using a 4-bit down-counter; ACCESS→RESP unconditionally; RESP→IDLE when resp_ready=1.
REQ-018 Latency: resp_valid SHALL first be high in cycle N+WAIT_CYCLES+2.
REQ-019 A store SHALL update the array at the end of the ACCESS cycle; only bytes whose req_be bit is set change.
REQ-020 A load SHALL register the full addressed word into resp_rdata at the end of ACCESS; req_be is ignored for loads.
REQ-021 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2].
REQ-022 Error: addr[1:0]≠0 or addr[31:2]≥DEPTH_WORDS → resp_err=1, resp_rdata=0, no array write; latency is unchanged.
REQ-023 A store with req_be=4'b0000 SHALL be a legal no-op with resp_err=0.
REQ-024 resp_rdata and resp_err SHALL be held stable while resp_valid && !resp_ready; there is no timeout.
REQ-025 Request inputs are don't-care outside the acceptance cycle; a change to them during WAIT/ACCESS/RESP SHALL NOT affect the operation in flight.
REQ-026 Only one request may be outstanding; the next accept is possible no earlier than the cycle after the RESP handshake.
REQ-027 Read-after-write: a load accepted after a store's response handshake SHALL return the stored data.

Reset
REQ-028 While rst=1: state=IDLE, counter=0, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-029 In the first cycle after rst deasserts, req_ready=1.
REQ-030 Reset during WAIT/ACCESS/RESP SHALL abort the operation; a store whose ACCESS edge coincides with rst=1 SHALL NOT write.
REQ-031 Array contents SHALL NOT be reset.

Structure
REQ-032 Shared package mem_pkg SHALL hold the state enum type and the default DEPTH_WORDS/WAIT_CYCLES constants.
REQ-033 Sub-module mem_array SHALL implement a single-port synchronous word RAM with a 4-bit byte-write enable; mem_responder holds the FSM, the counter and the capture registers.

Verification
REQ-034 Reset, then store addr=0x10, wdata=0xDEADBEEF, be=4'hF; then load addr=0x10 → resp_rdata=0xDEADBEEF, err=0, resp_valid first high at N+4 (WAIT_CYCLES=2).
REQ-035 Array word 0x20 holds 0x11223344; store wdata=0xAABBCCDD, be=4'b0101; then load 0x20 → 0x11BB33DD.
REQ-036 Load addr=0x13 → err=1, rdata=0; store addr=4·DEPTH_WORDS → err=1, and a subsequent read of word 0 is unchanged.
REQ-037 Hold resp_ready=0 for 5 cycles in RESP → resp_valid, rdata and err stable, req_ready=0; raise resp_ready → req_ready=1 in the next cycle.
REQ-038 Assert rst in the ACCESS cycle of a store to 0x40 with wdata=0x5A5A5A5A → no response; a later load of 0x40 returns the prior value.
REQ-039 Repeat REQ-034 with WAIT_CYCLES=0 → resp_valid first high at N+2.
